// File: rtl/dr32e_lsu_mon_pkg.sv
// Shared types for the DR32E load/store bus monitor.
// Violation codes, pending-entry layout and default depth.
package dr32e_lsu_mon_pkg;

  typedef enum logic [2:0] {
    VIOL_NONE         = 3'd0,
    VIOL_RVALID_EMPTY = 3'd1,
    VIOL_REQ_DROPPED  = 3'd2,
    VIOL_ATTR_CHANGED = 3'd3,
    VIOL_OVERFLOW     = 3'd4,
    VIOL_BE_ZERO      = 3'd5
  } viol_code_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
  } lsu_entry_t;

  localparam int unsigned DefMaxOutstanding = 2;

  // Lowest code wins when several checks fire together.
  function automatic viol_code_e first_viol(
    input logic [5:1] hits
  );
    viol_code_e code;
    code = VIOL_NONE;
    priority case (1'b1)
      hits[1]: code = VIOL_RVALID_EMPTY;
      hits[2]: code = VIOL_REQ_DROPPED;
      hits[3]: code = VIOL_ATTR_CHANGED;
      hits[4]: code = VIOL_OVERFLOW;
      hits[5]: code = VIOL_BE_ZERO;
      default: code = VIOL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dr32e_lsu_mon_fifo.sv
// In-order pending-transaction queue for the LSU bus monitor.
// Push while full is accepted only together with a pop.
module dr32e_lsu_mon_fifo
  import dr32e_lsu_mon_pkg::*;
#(
  parameter  int unsigned Depth = DefMaxOutstanding,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  lsu_entry_t      wdata,
  output lsu_entry_t      rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  lsu_entry_t      mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] cnt;
  logic            wr_en;
  logic            rd_en;

  function automatic logic [PtrW-1:0] bump(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == CntW'(Depth));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (rd_en) rd_ptr <= bump(rd_ptr);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dr32e_lsu_bus_monitor.sv
// Passive protocol monitor for the DR32E LSU data bus.
// Matches responses to requests, counts traffic, flags violations.
module dr32e_lsu_bus_monitor
  import dr32e_lsu_mon_pkg::*;
#(
  parameter  logic        MemECC         = 1'b0,
  parameter  int unsigned MemDataWidth   = MemECC ? 39 : 32,
  parameter  int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter  int unsigned CntWidth       = 32,
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic                    data_err_i,
  input  logic [31:0]             data_addr_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [MemDataWidth-1:0] data_rdata_i,
  input  logic                    clr_i,
  output logic [OutW-1:0]         outstanding_o,
  output logic [CntWidth-1:0]     load_cnt_o,
  output logic [CntWidth-1:0]     store_cnt_o,
  output logic [CntWidth-1:0]     err_cnt_o,
  output logic                    resp_valid_o,
  output logic [31:0]             resp_addr_o,
  output logic                    resp_we_o,
  output logic [3:0]              resp_be_o,
  output logic                    resp_err_o,
  output logic [MemDataWidth-1:0] resp_rdata_o,
  output logic                    viol_o,
  output logic [2:0]              viol_code_o,
  output logic                    viol_sticky_o
);

  lsu_entry_t cur_entry;
  lsu_entry_t head;
  lsu_entry_t prev_entry;
  logic       prev_hold;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       pop;
  logic       push;
  logic       ovf;
  logic [5:1] hits;
  logic       viol_any;
  viol_code_e viol_code_q;

  assign cur_entry = '{addr: data_addr_i,
                       we:   data_we_i,
                       be:   data_be_i};

  assign accept = data_req_i & data_gnt_i;
  assign pop    = data_rvalid_i & ~fifo_empty;
  assign ovf    = accept & fifo_full & ~pop;
  assign push   = accept & ~ovf;

  dr32e_lsu_mon_fifo #(
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .wdata (cur_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

  assign hits[1] = data_rvalid_i & fifo_empty;
  assign hits[2] = prev_hold & ~data_req_i;
  assign hits[3] = prev_hold & data_req_i &
                   (cur_entry != prev_entry);
  assign hits[4] = ovf;
  assign hits[5] = data_req_i & (data_be_i == 4'h0);
  assign viol_any = |hits;

  // Tracks a request that is still waiting for its grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_hold  <= 1'b0;
      prev_entry <= '0;
    end else begin
      prev_hold  <= data_req_i & ~data_gnt_i;
      prev_entry <= cur_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_o <= 1'b0;
      resp_addr_o  <= '0;
      resp_we_o    <= 1'b0;
      resp_be_o    <= '0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      resp_valid_o <= pop;
      if (pop) begin
        resp_addr_o  <= head.addr;
        resp_we_o    <= head.we;
        resp_be_o    <= head.be;
        resp_err_o   <= data_err_i;
        resp_rdata_o <= head.we ? '0 : data_rdata_i;
      end
    end
  end

  function automatic logic [CntWidth-1:0] sat_inc(
    input logic [CntWidth-1:0] v,
    input logic                en
  );
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else if (clr_i) begin
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      load_cnt_o  <= sat_inc(load_cnt_o, pop & ~head.we);
      store_cnt_o <= sat_inc(store_cnt_o, pop & head.we);
      err_cnt_o   <= sat_inc(err_cnt_o, pop & data_err_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_o        <= 1'b0;
      viol_code_q   <= VIOL_NONE;
      viol_sticky_o <= 1'b0;
    end else begin
      viol_o <= viol_any;
      if (clr_i) begin
        viol_code_q   <= VIOL_NONE;
        viol_sticky_o <= 1'b0;
      end else if (viol_any && !viol_sticky_o) begin
        viol_code_q   <= first_viol(hits);
        viol_sticky_o <= 1'b1;
      end
    end
  end

  assign viol_code_o = viol_code_q;

endmodule
